tcdm_bank_responder: RTL and testbench

//  Single-bank TCDM responder (slave end of hwpe_stream_intf_tcdm): serves load/store requests

---
 rtl/tcdm_bank_responder_pkg.sv | 19 +
 rtl/hwpe_stream_intf_tcdm.sv | 14 +
 rtl/tcdm_rr_arbiter.sv | 59 +++++
 rtl/tcdm_bank_responder.sv | 135 +++++++++++++
 tb/tb_tcdm_bank_responder.sv | 249 ++++++++++++++++++++++++
 5 files changed

// File: rtl/tcdm_bank_responder_pkg.sv
// Shared types and constants for the TCDM bank responder.
package hwpe_stream_package;

  // Read data returned for any access outside the bank's address window.
  localparam logic [31:0] TCDM_OOB_PATTERN = 32'hDEAD_BEEF;

  // Status visible to the surrounding bench / system.
  typedef struct packed {
    logic [31:0] rd_cnt;
    logic [31:0] wr_cnt;
    logic        oob;
  } tcdm_resp_flags_t;

  // Saturating 32-bit increment for the access counters.
  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == '1) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/hwpe_stream_intf_tcdm.sv
// TCDM request/response bundle shared by streamer masters and memory slaves.
interface hwpe_stream_intf_tcdm;
  logic        req;
  logic        gnt;
  logic [31:0] add;
  logic        wen;
  logic [3:0]  be;
  logic [31:0] data;
  logic [31:0] r_data;
  logic        r_valid;

  modport master (output req, add, wen, be, data, input gnt, r_data, r_valid);
  modport slave  (input req, add, wen, be, data, output gnt, r_data, r_valid);
endinterface

// File: rtl/tcdm_rr_arbiter.sv
// Round-robin arbiter: one-hot grant among unmasked requesters, search starts at rr_q.
module tcdm_rr_arbiter #(
  parameter  int unsigned NB_PORTS = 2,
  localparam int unsigned IDX_W    = (NB_PORTS > 1) ? $clog2(NB_PORTS) : 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                clear,
  input  logic [NB_PORTS-1:0] req,
  input  logic [NB_PORTS-1:0] mask,
  output logic [NB_PORTS-1:0] gnt,
  output logic [IDX_W-1:0]    gnt_idx,
  output logic                gnt_valid
);

  logic [IDX_W-1:0]    rr_q;
  logic [IDX_W-1:0]    rr_d;
  logic [NB_PORTS-1:0] eligible;
  logic [IDX_W:0]      cand;

  // Pick the first eligible port at or after rr_q, wrapping; nothing is granted while reset or clear is held.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no path leaves it unassigned (no latch).
    eligible  = req & ~mask;
    gnt       = '0;
    gnt_idx   = '0;
    gnt_valid = 1'b0;
    cand      = '0;
    if (!(clear || rst)) begin
      for (int i = 0; i < NB_PORTS; i++) begin
        cand = {1'b0, rr_q} + (IDX_W+1)'(i);
        if (cand >= (IDX_W+1)'(NB_PORTS)) cand = cand - (IDX_W+1)'(NB_PORTS);
        if (!gnt_valid && eligible[cand[IDX_W-1:0]]) begin
          gnt_valid = 1'b1;
          gnt_idx   = cand[IDX_W-1:0];
        end
      end
      if (gnt_valid) gnt[gnt_idx] = 1'b1;
    end
  end

  // Advance the pointer past the winner; hold when idle, restart at port 0 on clear.
  always_comb begin
    rr_d = rr_q;
    if (clear) begin
      rr_d = '0;
    end else if (gnt_valid) begin
      rr_d = (gnt_idx == IDX_W'(NB_PORTS - 1)) ? '0 : gnt_idx + 1'b1;
    end
  end

  // Round-robin pointer register.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (rst) rr_q <= '0;
    else     rr_q <= rr_d;
  end

endmodule

// File: rtl/tcdm_bank_responder.sv
// Single-bank TCDM slave: round-robin arbitration over NB_PORTS masters, one access per cycle,
// byte-enabled writes, fixed one-cycle response, access counters and sticky out-of-range flag.
module tcdm_bank_responder
  import hwpe_stream_package::*;
#(
  parameter int unsigned NB_PORTS  = 2,
  parameter int unsigned NB_WORDS  = 1024,
  parameter logic [31:0] BASE_ADDR = 32'h1000_0000
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  clear_i,
  input  logic [NB_PORTS-1:0]   gnt_mask_i,
  hwpe_stream_intf_tcdm.slave   tcdm_slave [NB_PORTS],
  output tcdm_resp_flags_t      flags_o
);

  localparam int unsigned IDX_W    = (NB_PORTS > 1) ? $clog2(NB_PORTS) : 1;
  localparam int unsigned AW       = $clog2(NB_WORDS);
  localparam logic [32:0] END_ADDR = {1'b0, BASE_ADDR} + 33'(4 * NB_WORDS);

  // Flattened view of the interface array.
  logic [NB_PORTS-1:0] req;
  logic [NB_PORTS-1:0] gnt;
  logic [NB_PORTS-1:0] req_wen;
  logic [31:0]         req_add  [NB_PORTS];
  logic [3:0]          req_be   [NB_PORTS];
  logic [31:0]         req_data [NB_PORTS];

  logic [IDX_W-1:0] gnt_idx;
  logic             gnt_valid;

  // Selected request.
  logic [31:0] sel_add;
  logic        sel_wen;
  logic [3:0]  sel_be;
  logic [31:0] sel_data;
  logic [31:0] offset;
  logic [AW-1:0] word_idx;
  logic        in_range;
  logic        do_rd;
  logic        do_wr;
  logic        unused_offset_bits;

  // Response stage and status.
  logic             resp_valid_q;
  logic [IDX_W-1:0] resp_idx_q;
  logic [31:0]      resp_data_q;
  tcdm_resp_flags_t flags_q;

  logic [31:0] mem [NB_WORDS];

  for (genvar k = 0; k < NB_PORTS; k++) begin : g_port
    assign req[k]      = tcdm_slave[k].req;
    assign req_wen[k]  = tcdm_slave[k].wen;
    assign req_add[k]  = tcdm_slave[k].add;
    assign req_be[k]   = tcdm_slave[k].be;
    assign req_data[k] = tcdm_slave[k].data;
    assign tcdm_slave[k].gnt     = gnt[k];
    assign tcdm_slave[k].r_valid = resp_valid_q && (resp_idx_q == IDX_W'(k));
    assign tcdm_slave[k].r_data  = (resp_valid_q && (resp_idx_q == IDX_W'(k))) ? resp_data_q : '0;
  end

  tcdm_rr_arbiter #(
    .NB_PORTS (NB_PORTS)
  ) i_arbiter (
    .clk       (clk_i),
    .rst       (rst_i),
    .clear     (clear_i),
    .req       (req),
    .mask      (gnt_mask_i),
    .gnt       (gnt),
    .gnt_idx   (gnt_idx),
    .gnt_valid (gnt_valid)
  );

  assign sel_add  = req_add[gnt_idx];
  assign sel_wen  = req_wen[gnt_idx];
  assign sel_be   = req_be[gnt_idx];
  assign sel_data = req_data[gnt_idx];

  // Window check in 33 bits so a bank near the top of the address map cannot wrap.
  assign in_range = ({1'b0, sel_add} >= {1'b0, BASE_ADDR}) && ({1'b0, sel_add} < END_ADDR);
  assign offset   = sel_add - BASE_ADDR;
  assign word_idx = offset[2 +: AW];
  assign do_rd    = gnt_valid &  sel_wen;
  assign do_wr    = gnt_valid & ~sel_wen;

  // Byte-in-word and above-window offset bits carry no information for the array index.
  assign unused_offset_bits = ^{offset[31:2+AW], offset[1:0]};

  // Byte-enabled write port; out-of-range writes are discarded.
  always_ff @(posedge clk_i) begin
    // NOTE: the memory array is deliberately not reset; contents are undefined until written.
    if (do_wr && in_range) begin
      for (int b = 0; b < 4; b++) begin
        if (sel_be[b]) mem[word_idx][8*b +: 8] <= sel_data[8*b +: 8];
      end
    end
  end

  // One-cycle response: read data, OOB pattern, or zero for writes; clear drops anything pending.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      resp_valid_q <= 1'b0;
      resp_idx_q   <= '0;
      resp_data_q  <= '0;
    end else if (clear_i) begin
      resp_valid_q <= 1'b0;
      resp_idx_q   <= '0;
      resp_data_q  <= '0;
    end else begin
      resp_valid_q <= gnt_valid;
      resp_idx_q   <= gnt_idx;
      if (do_rd) resp_data_q <= in_range ? mem[word_idx] : TCDM_OOB_PATTERN;
      else       resp_data_q <= '0;
    end
  end

  // Saturating access counters and sticky out-of-range flag.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      flags_q <= '0;
    end else if (clear_i) begin
      flags_q <= '0;
    end else begin
      if (do_rd) flags_q.rd_cnt <= sat_inc(flags_q.rd_cnt);
      if (do_wr) flags_q.wr_cnt <= sat_inc(flags_q.wr_cnt);
      if (gnt_valid && !in_range) flags_q.oob <= 1'b1;
    end
  end

  assign flags_o = flags_q;

endmodule

// File: tb/tb_tcdm_bank_responder.sv
// Directed bench for tcdm_bank_responder with two ports and the default 1024-word bank.
module tb_tcdm_bank_responder;
  import hwpe_stream_package::*;

  localparam int unsigned NB_PORTS = 2;
  localparam int unsigned NB_WORDS = 1024;
  localparam logic [31:0] BASE     = 32'h1000_0000;

  logic             clk = 1'b0;
  logic             rst;
  logic             clear;
  logic [1:0]       gnt_mask;
  tcdm_resp_flags_t flags;

  logic [1:0]  req_d;
  logic [1:0]  wen_d;
  logic [31:0] add_d  [2];
  logic [3:0]  be_d   [2];
  logic [31:0] data_d [2];
  logic [1:0]  gnt_v;
  logic [1:0]  rv_v;
  logic [31:0] rd_v   [2];

  int total = 0;
  int bad   = 0;
  int exp_rd = 0;
  int exp_wr = 0;

  hwpe_stream_intf_tcdm tcdm [NB_PORTS] ();

  for (genvar g = 0; g < NB_PORTS; g++) begin : g_tb_port
    assign tcdm[g].req  = req_d[g];
    assign tcdm[g].wen  = wen_d[g];
    assign tcdm[g].add  = add_d[g];
    assign tcdm[g].be   = be_d[g];
    assign tcdm[g].data = data_d[g];
    assign gnt_v[g]     = tcdm[g].gnt;
    assign rv_v[g]      = tcdm[g].r_valid;
    assign rd_v[g]      = tcdm[g].r_data;
  end

  tcdm_bank_responder #(
    .NB_PORTS  (NB_PORTS),
    .NB_WORDS  (NB_WORDS),
    .BASE_ADDR (BASE)
  ) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .clear_i    (clear),
    .gnt_mask_i (gnt_mask),
    .tcdm_slave (tcdm),
    .flags_o    (flags)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_port(input int p, input logic r, input logic w, input logic [31:0] a,
                          input logic [3:0] b, input logic [31:0] d);
    req_d[p] = r; wen_d[p] = w; add_d[p] = a; be_d[p] = b; data_d[p] = d;
  endtask

  task automatic idle();
    req_d = 2'b00;
  endtask

  task automatic test_reset();
    rst = 1'b1; clear = 1'b0; gnt_mask = 2'b00;
    set_port(0, 1'b1, 1'b1, BASE, 4'h0, 32'h0);
    set_port(1, 1'b1, 1'b1, BASE + 32'h4, 4'h0, 32'h0);
    step(); #1;
    total++; if (gnt_v !== 2'b00) begin bad++; $display("FAIL reset_gnt: got %b want 00", gnt_v); end
    total++; if (rv_v !== 2'b00) begin bad++; $display("FAIL reset_rvalid: got %b want 00", rv_v); end
    total++; if (rd_v[0] !== 32'h0) begin bad++; $display("FAIL reset_rdata0: got %h want 0", rd_v[0]); end
    total++; if (rd_v[1] !== 32'h0) begin bad++; $display("FAIL reset_rdata1: got %h want 0", rd_v[1]); end
    total++; if (flags !== '0) begin bad++; $display("FAIL reset_flags: got %h want 0", flags); end
    idle();
    step();
    rst = 1'b0;
    step();
  endtask

  task automatic test_single();
    set_port(0, 1'b1, 1'b0, BASE + 32'h10, 4'hF, 32'hA5A5_1234); #1;
    total++; if (gnt_v !== 2'b01) begin bad++; $display("FAIL single_wr_gnt: got %b want 01", gnt_v); end
    step(); exp_wr++;
    total++; if (rv_v !== 2'b01) begin bad++; $display("FAIL single_wr_rvalid: got %b want 01", rv_v); end
    total++; if (rd_v[0] !== 32'h0) begin bad++; $display("FAIL single_wr_rdata: got %h want 0", rd_v[0]); end
    set_port(0, 1'b1, 1'b1, BASE + 32'h10, 4'h0, 32'h0); #1;
    total++; if (gnt_v !== 2'b01) begin bad++; $display("FAIL single_rd_gnt: got %b want 01", gnt_v); end
    step(); exp_rd++;
    total++; if (rv_v !== 2'b01) begin bad++; $display("FAIL single_rd_rvalid: got %b want 01", rv_v); end
    total++; if (rd_v[0] !== 32'hA5A5_1234) begin bad++; $display("FAIL single_rd_rdata: got %h want a5a51234", rd_v[0]); end
    total++; if (rd_v[1] !== 32'h0) begin bad++; $display("FAIL single_idle_port_rdata: got %h want 0", rd_v[1]); end
    idle();
    step();
    total++; if (rv_v !== 2'b00) begin bad++; $display("FAIL single_no_req_rvalid: got %b want 00", rv_v); end
  endtask

  task automatic test_byte_enable();
    set_port(1, 1'b1, 1'b0, BASE, 4'hF, 32'h0000_0000);
    step(); exp_wr++;
    set_port(1, 1'b1, 1'b0, BASE, 4'b0101, 32'hFFFF_FFFF); #1;
    total++; if (gnt_v !== 2'b10) begin bad++; $display("FAIL be_wr_gnt: got %b want 10", gnt_v); end
    step(); exp_wr++;
    total++; if (rv_v !== 2'b10) begin bad++; $display("FAIL be_wr_rvalid: got %b want 10", rv_v); end
    total++; if (rd_v[1] !== 32'h0) begin bad++; $display("FAIL be_wr_rdata: got %h want 0", rd_v[1]); end
    set_port(1, 1'b1, 1'b1, BASE, 4'h0, 32'h0);
    step(); exp_rd++;
    total++; if (rd_v[1] !== 32'h00FF_00FF) begin bad++; $display("FAIL be_readback: got %h want 00ff00ff", rd_v[1]); end
    set_port(1, 1'b1, 1'b0, BASE, 4'h0, 32'h1234_5678);
    step(); exp_wr++;
    total++; if (rv_v !== 2'b10) begin bad++; $display("FAIL be0_rvalid: got %b want 10", rv_v); end
    set_port(1, 1'b1, 1'b1, BASE, 4'h0, 32'h0);
    step(); exp_rd++;
    total++; if (rd_v[1] !== 32'h00FF_00FF) begin bad++; $display("FAIL be0_readback: got %h want 00ff00ff", rd_v[1]); end
    set_port(1, 1'b1, 1'b0, BASE + 32'hFFC, 4'hF, 32'h0BAD_F00D);
    step(); exp_wr++;
    idle();
    total++; if (flags.rd_cnt !== 32'(exp_rd)) begin bad++; $display("FAIL be_rd_cnt: got %0d want %0d", flags.rd_cnt, exp_rd); end
    total++; if (flags.wr_cnt !== 32'(exp_wr)) begin bad++; $display("FAIL be_wr_cnt: got %0d want %0d", flags.wr_cnt, exp_wr); end
    step();
  endtask

  task automatic test_clear();
    clear = 1'b1;
    set_port(0, 1'b1, 1'b1, BASE + 32'h10, 4'h0, 32'h0); #1;
    total++; if (gnt_v !== 2'b00) begin bad++; $display("FAIL clear_gnt: got %b want 00", gnt_v); end
    step();
    clear = 1'b0; idle(); exp_rd = 0; exp_wr = 0;
    total++; if (flags !== '0) begin bad++; $display("FAIL clear_flags: got %h want 0", flags); end
    total++; if (rv_v !== 2'b00) begin bad++; $display("FAIL clear_rvalid: got %b want 00", rv_v); end
  endtask

  task automatic test_round_robin();
    logic [1:0]  want_g;
    logic [31:0] want_d;
    set_port(0, 1'b1, 1'b1, BASE + 32'h10, 4'h0, 32'h0);
    set_port(1, 1'b1, 1'b1, BASE, 4'h0, 32'h0);
    for (int i = 0; i < 8; i++) begin
      want_g = (i % 2 == 0) ? 2'b01 : 2'b10;
      want_d = (i % 2 == 0) ? 32'hA5A5_1234 : 32'h00FF_00FF;
      #1;
      total++; if (gnt_v !== want_g) begin bad++; $display("FAIL rr_gnt[%0d]: got %b want %b", i, gnt_v, want_g); end
      step(); exp_rd++;
      total++; if (rv_v !== want_g) begin bad++; $display("FAIL rr_rvalid[%0d]: got %b want %b", i, rv_v, want_g); end
      total++; if (rd_v[i % 2] !== want_d) begin bad++; $display("FAIL rr_rdata[%0d]: got %h want %h", i, rd_v[i % 2], want_d); end
      total++; if (rd_v[1 - (i % 2)] !== 32'h0) begin bad++; $display("FAIL rr_other_rdata[%0d]: got %h want 0", i, rd_v[1 - (i % 2)]); end
    end
    idle();
    total++; if (flags.rd_cnt !== 32'd8) begin bad++; $display("FAIL rr_rd_cnt: got %0d want 8", flags.rd_cnt); end
    total++; if (flags.wr_cnt !== 32'd0) begin bad++; $display("FAIL rr_wr_cnt: got %0d want 0", flags.wr_cnt); end
    step();
  endtask

  task automatic test_mask();
    gnt_mask = 2'b01;
    set_port(0, 1'b1, 1'b1, BASE + 32'h10, 4'h0, 32'h0);
    set_port(1, 1'b1, 1'b1, BASE, 4'h0, 32'h0);
    for (int i = 0; i < 3; i++) begin
      #1;
      total++; if (gnt_v !== 2'b10) begin bad++; $display("FAIL mask_gnt[%0d]: got %b want 10", i, gnt_v); end
      step(); exp_rd++;
      total++; if (rv_v !== 2'b10) begin bad++; $display("FAIL mask_rvalid[%0d]: got %b want 10", i, rv_v); end
    end
    gnt_mask = 2'b00; #1;
    total++; if (gnt_v !== 2'b01) begin bad++; $display("FAIL unmask_gnt: got %b want 01", gnt_v); end
    step(); exp_rd++;
    total++; if (rd_v[0] !== 32'hA5A5_1234) begin bad++; $display("FAIL unmask_rdata: got %h want a5a51234", rd_v[0]); end
    idle();
    total++; if (flags.rd_cnt !== 32'(exp_rd)) begin bad++; $display("FAIL mask_rd_cnt: got %0d want %0d", flags.rd_cnt, exp_rd); end
    step();
  endtask

  task automatic test_oob();
    set_port(1, 1'b1, 1'b1, BASE + 32'(4 * NB_WORDS), 4'h0, 32'h0); #1;
    total++; if (gnt_v !== 2'b10) begin bad++; $display("FAIL oob_rd_gnt: got %b want 10", gnt_v); end
    step(); exp_rd++; idle();
    total++; if (rv_v !== 2'b10) begin bad++; $display("FAIL oob_rd_rvalid: got %b want 10", rv_v); end
    total++; if (rd_v[1] !== 32'hDEAD_BEEF) begin bad++; $display("FAIL oob_rd_rdata: got %h want deadbeef", rd_v[1]); end
    total++; if (flags.oob !== 1'b1) begin bad++; $display("FAIL oob_flag_set: got %b want 1", flags.oob); end
    set_port(0, 1'b1, 1'b0, BASE - 32'h4, 4'hF, 32'h1111_1111); #1;
    total++; if (gnt_v !== 2'b01) begin bad++; $display("FAIL oob_wr_gnt: got %b want 01", gnt_v); end
    step(); exp_wr++;
    total++; if (rd_v[0] !== 32'h0) begin bad++; $display("FAIL oob_wr_rdata: got %h want 0", rd_v[0]); end
    set_port(0, 1'b1, 1'b1, BASE + 32'hFFC, 4'h0, 32'h0);
    step(); exp_rd++; idle();
    total++; if (rd_v[0] !== 32'h0BAD_F00D) begin bad++; $display("FAIL oob_wr_discarded: got %h want 0badf00d", rd_v[0]); end
    step();
    total++; if (flags.oob !== 1'b1) begin bad++; $display("FAIL oob_flag_sticky: got %b want 1", flags.oob); end
    total++; if (flags.rd_cnt !== 32'(exp_rd)) begin bad++; $display("FAIL oob_rd_cnt: got %0d want %0d", flags.rd_cnt, exp_rd); end
    total++; if (flags.wr_cnt !== 32'(exp_wr)) begin bad++; $display("FAIL oob_wr_cnt: got %0d want %0d", flags.wr_cnt, exp_wr); end
    clear = 1'b1;
    set_port(1, 1'b1, 1'b1, BASE, 4'h0, 32'h0); #1;
    total++; if (gnt_v !== 2'b00) begin bad++; $display("FAIL oob_clear_gnt: got %b want 00", gnt_v); end
    step();
    clear = 1'b0; idle(); exp_rd = 0; exp_wr = 0;
    total++; if (flags !== '0) begin bad++; $display("FAIL oob_clear_flags: got %h want 0", flags); end
    total++; if (rv_v !== 2'b00) begin bad++; $display("FAIL oob_clear_rvalid: got %b want 00", rv_v); end
    step();
  endtask

  task automatic test_reset_mid();
    set_port(0, 1'b1, 1'b1, BASE + 32'h10, 4'h0, 32'h0); #1;
    total++; if (gnt_v !== 2'b01) begin bad++; $display("FAIL rstmid_gnt: got %b want 01", gnt_v); end
    step();
    total++; if (rv_v !== 2'b01) begin bad++; $display("FAIL rstmid_pre_rvalid: got %b want 01", rv_v); end
    rst = 1'b1; idle(); #1;
    total++; if (rv_v !== 2'b00) begin bad++; $display("FAIL rstmid_rvalid: got %b want 00", rv_v); end
    total++; if (rd_v[0] !== 32'h0) begin bad++; $display("FAIL rstmid_rdata: got %h want 0", rd_v[0]); end
    step();
    rst = 1'b0;
    set_port(0, 1'b1, 1'b1, BASE + 32'h10, 4'h0, 32'h0);
    set_port(1, 1'b1, 1'b1, BASE, 4'h0, 32'h0); #1;
    total++; if (gnt_v !== 2'b01) begin bad++; $display("FAIL rstmid_rr_restart: got %b want 01", gnt_v); end
    step(); idle();
    total++; if (rd_v[0] !== 32'hA5A5_1234) begin bad++; $display("FAIL rstmid_mem_kept: got %h want a5a51234", rd_v[0]); end
    total++; if (flags.rd_cnt !== 32'd1) begin bad++; $display("FAIL rstmid_rd_cnt: got %0d want 1", flags.rd_cnt); end
    step();
  endtask

  initial begin
    req_d = 2'b00; wen_d = 2'b11;
    for (int p = 0; p < 2; p++) begin
      add_d[p] = 32'h0; be_d[p] = 4'h0; data_d[p] = 32'h0;
    end
    test_reset();
    test_single();
    test_byte_enable();
    test_clear();
    test_round_robin();
    test_mask();
    test_oob();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, expected completion earlier", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
